ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the RISC-V pipeline, directly upstream of the ALU.
- Latches decoded operands and control signals from ID each cycle.
- Applies EX-stage operand forwarding from the MEM and WB stages, and selects the immediate for SrcB.
- Detects load-use hazards, inserts a bubble, and drives the ALU SrcA/SrcB/Operation inputs.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU Operation code width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_data  in  DATA_WIDTH  register file read port 1
- id_rs2_data  in  DATA_WIDTH  register file read port 2
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1  in  REG_ADDR_W  source 1 index
- id_rs2  in  REG_ADDR_W  source 2 index
- id_rd  in  REG_ADDR_W  destination index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_alu_src  in  1  1: SrcB = immediate
- id_alu_op  in  OPCODE_LENGTH  ALU Operation code
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- flush  in  1  branch taken / redirect; kill the instruction entering EX
- mem_rd  in  REG_ADDR_W  destination index in MEM
- mem_reg_write  in  1  MEM writes rd
- mem_result  in  DATA_WIDTH  MEM forward value
- wb_rd  in  REG_ADDR_W  destination index in WB
- wb_reg_write  in  1  WB writes rd
- wb_result  in  DATA_WIDTH  WB forward value
- stall  out  1  hold PC and IF/ID (load-use)
- ex_valid  out  1  EX holds a real instruction
- ex_pc  out  DATA_WIDTH  registered PC
- ex_src_a  out  DATA_WIDTH  ALU SrcA
- ex_src_b  out  DATA_WIDTH  ALU SrcB
- ex_store_data  out  DATA_WIDTH  forwarded rs2 for stores
- ex_operation  out  OPCODE_LENGTH  ALU Operation
- ex_rd  out  REG_ADDR_W  registered rd
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control, gated by ex_valid

Behaviour:
- Reset: asynchronous on rst_n low; all EX registers are cleared to 0. While in reset:
  - ex_valid=0; every control output = 0; ex_operation=4'b0000.
  - ex_src_a, ex_src_b, ex_store_data are driven per the forwarding rules from zeroed registers, so they are 0 unless MEM/WB inputs match index 0, which is excluded.
  - stall=0.
- Register update on each clk rising edge, in priority order:
  1. flush=1: load a bubble (ex_valid=0, all control=0, ex_rd=0). Flush overrides stall.
  2. stall=1: load a bubble.
  3. Otherwise: load every id_* field; ex_valid=id_valid.
- Bubble data fields are don't-care; control bits must be 0.
- Latency: one cycle ID→EX. ex_src_a, ex_src_b, ex_store_data are combinational from the EX registers and the current MEM/WB inputs.
- Load-use stall (combinational): stall = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Stall lasts exactly one cycle, because the load moves to MEM and the next cycle forwards from WB.
  - stall is forced to 0 when flush=1.
- Forwarding, evaluated per source (rs1, rs2) using the registered index:
  - If mem_reg_write & mem_rd≠0 & mem_rd==src: use mem_result.
  - Else if wb_reg_write & wb_rd≠0 & wb_rd==src: use wb_result.
  - Else: use the registered register-file data.
  - MEM has priority over WB.
  - Register index 0 is never forwarded; the register value is always used.
- ex_src_a = forwarded rs1.
- ex_store_data = forwarded rs2.
- ex_src_b = registered imm if alu_src=1, else forwarded rs2.
- Control outputs equal registered control AND ex_valid.
- Simultaneous flush and load-use: flush wins, stall=0, EX gets a bubble.
- Reset mid-stall: stall drops immediately because ex_valid clears.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → ex_valid=0, ex_reg_write=0, stall=0 immediately, with no clock edge required.
- ADD x3,x1,x2 with rs1_data=5, rs2_data=7, alu_op=0010, no hazards → next cycle ex_src_a=5, ex_src_b=7, ex_operation=0010, ex_rd=3, ex_valid=1.
- Double hit: EX x1 with mem_rd=1, mem_result=0xAA and wb_rd=1, wb_result=0xBB, both write-enabled → ex_src_a=0xAA. With mem_reg_write=0 → ex_src_a=0xBB. With rd=0 and result=0xFF → ex_src_a=register value.
- Load-use: EX holds LW x4 (mem_read=1, rd=4); ID holds ADD reading rs2=4 with use_rs2=1 → stall=1 for one cycle, ex_valid=0 next cycle. The following cycle the ADD enters EX and WB forwarding supplies wb_result.
- Load-use with flush=1 in the same cycle → stall=0, next cycle ex_valid=0 and ex_mem_read=0.
- ADDI with id_alu_src=1, imm=0xFFFFFFFC, rs2_data=9 and a MEM hit on rs2 with value 0x11 → ex_src_b=0xFFFFFFFC, ex_store_data=0x11.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. It applies MEM/WB operand forwarding,
// selects the immediate for SrcB and detects load-use hazards.
module ex_operand_stage #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 4,
   parameter int unsigned REG_ADDR_W    = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // decoded instruction from ID
   input  logic                     id_valid,
   input  logic [DATA_WIDTH-1:0]    id_pc,
   input  logic [DATA_WIDTH-1:0]    id_rs1_data,
   input  logic [DATA_WIDTH-1:0]    id_rs2_data,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [REG_ADDR_W-1:0]    id_rs1,
   input  logic [REG_ADDR_W-1:0]    id_rs2,
   input  logic [REG_ADDR_W-1:0]    id_rd,
   input  logic                     id_use_rs1,
   input  logic                     id_use_rs2,
   input  logic                     id_alu_src,
   input  logic [OPCODE_LENGTH-1:0] id_alu_op,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_mem_write,
   input  logic                     flush,
   // forwarding sources
   input  logic [REG_ADDR_W-1:0]    mem_rd,
   input  logic                     mem_reg_write,
   input  logic [DATA_WIDTH-1:0]    mem_result,
   input  logic [REG_ADDR_W-1:0]    wb_rd,
   input  logic                     wb_reg_write,
   input  logic [DATA_WIDTH-1:0]    wb_result,
   // hazard and EX outputs
   output logic                     stall,
   output logic                     ex_valid,
   output logic [DATA_WIDTH-1:0]    ex_pc,
   output logic [DATA_WIDTH-1:0]    ex_src_a,
   output logic [DATA_WIDTH-1:0]    ex_src_b,
   output logic [DATA_WIDTH-1:0]    ex_store_data,
   output logic [OPCODE_LENGTH-1:0] ex_operation,
   output logic [REG_ADDR_W-1:0]    ex_rd,
   output logic                     ex_reg_write,
   output logic                     ex_mem_read,
   output logic                     ex_mem_write
);

   // EX pipeline registers
   logic                     valid_q,     valid_d;
   logic [DATA_WIDTH-1:0]    pc_q,        pc_d;
   logic [DATA_WIDTH-1:0]    rs1_data_q,  rs1_data_d;
   logic [DATA_WIDTH-1:0]    rs2_data_q,  rs2_data_d;
   logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
   logic [REG_ADDR_W-1:0]    rs1_q,       rs1_d;
   logic [REG_ADDR_W-1:0]    rs2_q,       rs2_d;
   logic [REG_ADDR_W-1:0]    rd_q,        rd_d;
   logic                     alu_src_q,   alu_src_d;
   logic [OPCODE_LENGTH-1:0] alu_op_q,    alu_op_d;
   logic                     reg_write_q, reg_write_d;
   logic                     mem_read_q,  mem_read_d;
   logic                     mem_write_q, mem_write_d;

   logic                     rs1_hit, rs2_hit;
   logic                     load_use;
   logic                     bubble;
   logic [DATA_WIDTH-1:0]    fwd_a, fwd_b;

   // Load-use hazard: the load in EX has no data until WB, so hold ID for one cycle.
   always_comb begin
      rs1_hit  = id_use_rs1 && (id_rs1 == rd_q);
      rs2_hit  = id_use_rs2 && (id_rs2 == rd_q);
      load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid && (rs1_hit || rs2_hit);
      // A redirect kills the ID instruction, so there is nothing left to hold.
      stall    = load_use && !flush;
      bubble   = flush || load_use;
   end

   // Next-state: load ID, or a bubble with all control cleared on flush/stall.
   always_comb begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      alu_src_d   = id_alu_src;
      alu_op_d    = id_alu_op;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      if (bubble) begin
         valid_d     = 1'b0;
         // Clearing the source indices keeps a bubble from matching any forward.
         rs1_d       = '0;
         rs2_d       = '0;
         rd_d        = '0;
         alu_src_d   = 1'b0;
         alu_op_d    = '0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
      end
   end

   // EX register bank with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         alu_src_q   <= 1'b0;
         alu_op_q    <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         alu_src_q   <= alu_src_d;
         alu_op_q    <= alu_op_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   // Operand forwarding: MEM beats WB, x0 always reads the register file value.
   always_comb begin
      fwd_a = rs1_data_q;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q)) begin
         fwd_a = mem_result;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q)) begin
         fwd_a = wb_result;
      end
      fwd_b = rs2_data_q;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q)) begin
         fwd_b = mem_result;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q)) begin
         fwd_b = wb_result;
      end
   end

   // ALU inputs and control outputs, control qualified by the valid bit.
   always_comb begin
      ex_valid      = valid_q;
      ex_pc         = pc_q;
      ex_src_a      = fwd_a;
      ex_src_b      = alu_src_q ? imm_q : fwd_b;
      ex_store_data = fwd_b;
      ex_operation  = alu_op_q;
      ex_rd         = rd_q;
      ex_reg_write  = reg_write_q && valid_q;
      ex_mem_read   = mem_read_q  && valid_q;
      ex_mem_write  = mem_write_q && valid_q;
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_alu_src;
   logic [3:0]  id_alu_op;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        flush;
   logic [4:0]  mem_rd, wb_rd;
   logic        mem_reg_write, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic        stall, ex_valid;
   logic [31:0] ex_pc, ex_src_a, ex_src_b, ex_store_data;
   logic [3:0]  ex_operation;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;

   int checks   = 0;
   int failures = 0;

   ex_operand_stage #(
      .DATA_WIDTH    (32),
      .OPCODE_LENGTH (4),
      .REG_ADDR_W    (5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_pc         (id_pc),
      .id_rs1_data   (id_rs1_data),
      .id_rs2_data   (id_rs2_data),
      .id_imm        (id_imm),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .id_alu_src    (id_alu_src),
      .id_alu_op     (id_alu_op),
      .id_reg_write  (id_reg_write),
      .id_mem_read   (id_mem_read),
      .id_mem_write  (id_mem_write),
      .flush         (flush),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_result     (wb_result),
      .stall         (stall),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_src_a      (ex_src_a),
      .ex_src_b      (ex_src_b),
      .ex_store_data (ex_store_data),
      .ex_operation  (ex_operation),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'h0;
      wb_rd  = 5'd0; wb_reg_write  = 1'b0; wb_result  = 32'h0;
   endtask

   task automatic drive_lw_x4();
      id_valid = 1'b1; id_pc = 32'h200; id_rs1 = 5'd1; id_rs2 = 5'd0; id_rd = 5'd4;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b0; id_alu_src = 1'b1; id_imm = 32'h8;
      id_rs1_data = 32'h1000; id_rs2_data = 32'h0; id_alu_op = 4'b0010;
      id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b0;
   endtask

   task automatic drive_add_x5_x6_x4();
      id_valid = 1'b1; id_pc = 32'h204; id_rs1 = 5'd6; id_rs2 = 5'd4; id_rd = 5'd5;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_alu_src = 1'b0; id_imm = 32'h0;
      id_rs1_data = 32'h3; id_rs2_data = 32'h0; id_alu_op = 4'b0010;
      id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_alu_src = 1'b0; id_alu_op = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      id_mem_write = 1'b0; flush = 1'b0;
      clear_fwd();

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_operation", {28'b0, ex_operation}, 32'd0);
      chk("rst_src_a", ex_src_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD x3,x1,x2 with no hazards
      id_valid = 1'b1; id_pc = 32'h100; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
      id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      id_alu_op = 4'b0010; id_reg_write = 1'b1;
      step();
      chk("add_src_a", ex_src_a, 32'd5);
      chk("add_src_b", ex_src_b, 32'd7);
      chk("add_store", ex_store_data, 32'd7);
      chk("add_op", {28'b0, ex_operation}, 32'h2);
      chk("add_rd", {27'b0, ex_rd}, 32'd3);
      chk("add_valid", {31'b0, ex_valid}, 32'd1);
      chk("add_reg_write", {31'b0, ex_reg_write}, 32'd1);
      chk("add_pc", ex_pc, 32'h100);

      // Double hit on x1: MEM wins, then WB, then x0 is never forwarded
      mem_rd = 5'd1; mem_reg_write = 1'b1; mem_result = 32'hAA;
      wb_rd  = 5'd1; wb_reg_write  = 1'b1; wb_result  = 32'hBB;
      #1 chk("fwd_mem_prio", ex_src_a, 32'hAA);
      mem_reg_write = 1'b0;
      #1 chk("fwd_wb", ex_src_a, 32'hBB);
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
      wb_rd = 5'd0; wb_result = 32'hFF;
      #1 chk("fwd_x0", ex_src_a, 32'd5);
      clear_fwd();

      // Load-use: LW x4 in EX, ADD reading x4 in ID
      drive_lw_x4();
      step();
      drive_add_x5_x6_x4();
      #1;
      chk("lu_mem_read", {31'b0, ex_mem_read}, 32'd1);
      chk("lu_stall", {31'b0, stall}, 32'd1);
      step();
      chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
      chk("lu_bubble_rw", {31'b0, ex_reg_write}, 32'd0);
      chk("lu_stall_drop", {31'b0, stall}, 32'd0);
      mem_rd = 5'd4; mem_reg_write = 1'b1; mem_result = 32'h0;
      step();
      // Load now in WB, bubble in MEM
      mem_rd = 5'd0; mem_reg_write = 1'b0;
      wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h1234;
      id_valid = 1'b0;
      #1;
      chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
      chk("lu_add_src_a", ex_src_a, 32'h3);
      chk("lu_add_wb_fwd", ex_src_b, 32'h1234);
      chk("lu_add_rd", {27'b0, ex_rd}, 32'd5);
      chk("lu_no_stall", {31'b0, stall}, 32'd0);
      clear_fwd();

      // Load-use with simultaneous flush
      drive_lw_x4();
      step();
      drive_add_x5_x6_x4();
      flush = 1'b1;
      #1 chk("fl_stall", {31'b0, stall}, 32'd0);
      step();
      flush = 1'b0;
      id_valid = 1'b0;
      #1;
      chk("fl_valid", {31'b0, ex_valid}, 32'd0);
      chk("fl_mem_read", {31'b0, ex_mem_read}, 32'd0);
      chk("fl_reg_write", {31'b0, ex_reg_write}, 32'd0);

      // ADDI: immediate on SrcB, store data still forwarded from MEM
      id_valid = 1'b1; id_pc = 32'h300; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd7;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b0; id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC;
      id_rs1_data = 32'd1; id_rs2_data = 32'd9; id_alu_op = 4'b0010;
      id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
      step();
      mem_rd = 5'd2; mem_reg_write = 1'b1; mem_result = 32'h11;
      #1;
      chk("addi_src_b", ex_src_b, 32'hFFFF_FFFC);
      chk("addi_store", ex_store_data, 32'h11);
      chk("addi_src_a", ex_src_a, 32'd1);
      clear_fwd();

      // Reset in the middle of a stall
      drive_lw_x4();
      step();
      drive_add_x5_x6_x4();
      #1 chk("rs_stall_before", {31'b0, stall}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_stall_after", {31'b0, stall}, 32'd0);
      chk("rs_valid", {31'b0, ex_valid}, 32'd0);
      chk("rs_mem_read", {31'b0, ex_mem_read}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
